// File: rtl/quad_decoder.sv
// Quadrature decoder: two-flop synchronizers, per-channel glitch filter, Gray-phase decode and position counter.
// Define QDEC_ERR_EN to add the saturating err_count tally of illegal transitions.
module quad_decoder #(
    parameter int WIDTH = 4,
    parameter int FILT  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a,
    input  logic             b,
    input  logic             clear,
    output logic             step,
    output logic             UpDown,
    output logic [WIDTH-1:0] count,
    output logic             err
`ifdef QDEC_ERR_EN
    ,
    output logic [7:0]       err_count
`endif
);

    typedef enum logic [1:0] {
        MOVE_NONE,
        MOVE_UP,
        MOVE_DOWN,
        MOVE_ILLEGAL
    } move_t;

    localparam logic [3:0] FILT_LAST = 4'(FILT - 1);
    // The filter needs two sync stages plus FILT cycles before its state reflects the pins.
    localparam logic [4:0] ACQ_LAST  = 5'(FILT + 1);

    // Bit 1 carries channel A, bit 0 channel B throughout.
    logic [1:0] sync_s1;
    logic [1:0] sync_s2;
    logic [3:0] filt_cnt [2];
    logic [1:0] filt_state;
    logic [4:0] acq_cnt;
    logic       filt_valid;
    logic [1:0] ref_state;
    logic       ref_valid;
    logic [1:0] phase_delta;
    move_t      move;
    logic [WIDTH-1:0] count_next;

    // Map {a,b} onto a binary phase so a quadrature step becomes +1/-1 modulo 4.
    function automatic logic [1:0] phase_of(input logic [1:0] ab);
        return {ab[1], ab[1] ^ ab[0]};
    endfunction

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_s1 <= 2'b00;
            sync_s2 <= 2'b00;
        end else begin
            sync_s1 <= {a, b};
            sync_s2 <= sync_s1;
        end
    end

    // A channel moves only after the synchronized level has differed from it for FILT edges in a row.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_state  <= 2'b00;
            filt_cnt[0] <= 4'd0;
            filt_cnt[1] <= 4'd0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync_s2[i] == filt_state[i]) begin
                    filt_cnt[i] <= 4'd0;
                end else if (filt_cnt[i] == FILT_LAST) begin
                    filt_state[i] <= sync_s2[i];
                    filt_cnt[i]   <= 4'd0;
                end else begin
                    filt_cnt[i] <= filt_cnt[i] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acq_cnt    <= 5'd0;
            filt_valid <= 1'b0;
        end else if (!filt_valid) begin
            if (acq_cnt == ACQ_LAST) begin
                filt_valid <= 1'b1;
            end else begin
                acq_cnt <= acq_cnt + 5'd1;
            end
        end
    end

    // NOTE: combinational outputs get a default first so no latch is inferred.
    always_comb begin
        move        = MOVE_NONE;
        phase_delta = phase_of(filt_state) - phase_of(ref_state);
        if (ref_valid) begin
            case (phase_delta)
                2'd1:    move = MOVE_UP;
                2'd3:    move = MOVE_DOWN;
                2'd2:    move = MOVE_ILLEGAL;
                default: move = MOVE_NONE;
            endcase
        end
    end

    always_comb begin
        count_next = count;
        case (move)
            MOVE_UP:   count_next = count + WIDTH'(1);
            MOVE_DOWN: count_next = count - WIDTH'(1);
            default:   count_next = count;
        endcase
        if (clear) begin
            count_next = '0;
        end
    end

    // The reference always tracks the filtered state, so an illegal jump is adopted as the new origin.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ref_state <= 2'b00;
            ref_valid <= 1'b0;
            count     <= '0;
            UpDown    <= 1'b1;
            step      <= 1'b0;
            err       <= 1'b0;
        end else begin
            ref_state <= filt_state;
            ref_valid <= filt_valid;
            step      <= (move == MOVE_UP) || (move == MOVE_DOWN);
            err       <= (move == MOVE_ILLEGAL);
            count     <= count_next;
            if (move == MOVE_UP) begin
                UpDown <= 1'b1;
            end else if (move == MOVE_DOWN) begin
                UpDown <= 1'b0;
            end
        end
    end

`ifdef QDEC_ERR_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_count <= 8'd0;
        end else if (clear) begin
            err_count <= 8'd0;
        end else if ((move == MOVE_ILLEGAL) && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule
